uart_rx_sipo: RTL

//  UART receive front end: synchronises serial rx_in, detects start bit, samples each bit at
//  mid-bit using an oversampling tick, and shifts FRAME_BITS bits into a parallel frame.

---
 rtl/uart_rx_sipo_if.sv | 39 +++
 rtl/uart_rx_sipo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_sipo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_sipo_if
//   Bundles the serial-side inputs and parallel-side outputs of the UART
//   receive front end.
//   Signals:
//     baud_tick      one-clk enable pulse at OVERSAMPLE x baud rate
//     rx_in          asynchronous serial line, idle high
//     data_parll     last complete frame, [FRAME_BITS-1] = first bit received
//     recieved_flag  one-clk pulse when data_parll has just been updated
//     active         high while a frame is being received
//   Modports:
//     master  drives baud_tick / rx_in and observes the frame outputs
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_sipo_if #(
  parameter int FRAME_BITS = 11
);
  logic                  baud_tick;
  logic                  rx_in;
  logic [FRAME_BITS-1:0] data_parll;
  logic                  recieved_flag;
  logic                  active;

  modport master (
    output baud_tick,
    output rx_in,
    input  data_parll,
    input  recieved_flag,
    input  active
  );

  modport slave (
    input  baud_tick,
    input  rx_in,
    output data_parll,
    output recieved_flag,
    output active
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// ---------------------------------------------------------------------------
// uart_rx_sipo
//   UART receive front end. Synchronises rx_in, detects a start bit, samples
//   every bit at mid-bit using the oversampling baud_tick and shifts
//   FRAME_BITS raw bits (start, data, parity, stop) into a parallel frame.
//   No parity or stop checking is done here.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous, active-low reset
//     rx_bus   uart_rx_sipo_if.slave (baud_tick, rx_in in;
//              data_parll, recieved_flag, active out)
// ---------------------------------------------------------------------------
module uart_rx_sipo #(
  parameter int OVERSAMPLE  = 16,
  parameter int FRAME_BITS  = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  uart_rx_sipo_if.slave rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BITS_ALL  = 4'(FRAME_BITS);
  localparam logic [FRAME_BITS-1:0] DATA_RST = {1'b0, {(FRAME_BITS-1){1'b1}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  logic [1:0]            state_reg,  state_next;
  logic [TW-1:0]         tick_reg,   tick_next;
  logic [3:0]            bit_reg,    bit_next;
  logic [FRAME_BITS-1:0] shift_reg,  shift_next;
  logic [FRAME_BITS-1:0] data_reg,   data_next;
  logic                  flag_reg,   flag_next;

  // Synchroniser resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_bus.rx_in};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    flag_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rx_bus.baud_tick && !rx_s) begin
          state_next = ST_START;
          tick_next  = '0;
        end
      end

      ST_START: begin
        if (rx_bus.baud_tick) begin
          if (tick_reg == HALF_LAST) begin
            // Mid start bit: confirm the line is still low, otherwise it was a glitch.
            tick_next = '0;
            if (!rx_s) begin
              shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
              bit_next   = 4'd1;
              state_next = ST_SHIFT;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (rx_bus.baud_tick) begin
          if (tick_reg == FULL_LAST) begin
            // One full bit period after the previous mid-bit sample.
            tick_next  = '0;
            shift_next = {shift_reg[FRAME_BITS-2:0], rx_s};
            bit_next   = bit_reg + 4'd1;
            if (bit_next == BITS_ALL) begin
              state_next = ST_DONE;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Single clock regardless of baud_tick; we leave at mid stop bit so a
        // back-to-back start edge is still caught from IDLE.
        data_next  = shift_reg;
        flag_next  = 1'b1;
        tick_next  = '0;
        bit_next   = '0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= DATA_RST;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      flag_reg  <= flag_next;
    end
  end

  assign rx_bus.data_parll    = data_reg;
  assign rx_bus.recieved_flag = flag_reg;
  assign rx_bus.active        = (state_reg == ST_START) || (state_reg == ST_SHIFT);

endmodule
